// File: rtl/antilog_decoder.sv
// rtl/antilog_decoder.sv - antilog back end: expands log-domain {k,x} into (1.x)*2^k
// Two-stage valid/ready pipeline; stage 1 holds the operands, stage 2 the shifted product.
module antilog_decoder #(
  parameter int LOG2_WIDTH = 4,
  parameter int WIDTH      = 2**LOG2_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG2_WIDTH:0]   in_k,
  input  logic [WIDTH-2:0]      in_x,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    out_p,
  output logic                  busy
);

  localparam int EXT_W = 3*WIDTH-1;

  logic                 s1_valid_q, s1_valid_d;
  logic [LOG2_WIDTH:0]  s1_k_q, s1_k_d;
  logic [WIDTH-2:0]     s1_x_q, s1_x_d;
  logic                 s1_zero_q, s1_zero_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [2*WIDTH-1:0]   s2_p_q, s2_p_d;
  logic [2*WIDTH-1:0]   product;
  logic                 s2_adv;
  logic                 in_fire;

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_fire  = in_valid & in_ready;

  // Shift the implicit-one mantissa at full width, then drop the WIDTH-1 fraction bits (floor).
  assign product = s1_zero_q ? '0
                 : (2*WIDTH)'((EXT_W'({1'b1, s1_x_q}) << s1_k_q) >> (WIDTH-1));

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_k_d     = s1_k_q;
    s1_x_d     = s1_x_q;
    s1_zero_d  = s1_zero_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_k_d     = in_k;
      s1_x_d     = in_x;
      s1_zero_d  = in_zero;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // out_p is held after a transfer; only the valid flag drops.
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_p_d     = product;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_k_q     <= '0;
      s1_x_q     <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_k_q     <= s1_k_d;
      s1_x_q     <= s1_x_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_p     = s2_p_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_antilog_decoder.sv
// tb/tb_antilog_decoder.sv - directed and randomized checks of antilog_decoder
// Scoreboard queue holds expected products in acceptance order.
module tb_antilog_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_k;
  logic [14:0] in_x;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        busy;

  int errors;
  int checks;
  int pops;
  int issued;
  int cyc;
  logic [31:0] exp_q[$];
  logic [31:0] held;

  antilog_decoder #(.LOG2_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_k(in_k), .in_x(in_x), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_p(input logic [4:0] k, input logic [14:0] x, input logic z);
    longint unsigned m;
    m = 64'd32768 + 64'(x);
    if (z) return 32'd0;
    return 32'((m * (64'd1 << k)) / 64'd32768);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] k, input logic [14:0] x, input logic z);
    in_valid = v;
    in_k     = k;
    in_x     = x;
    in_zero  = z;
  endtask

  // One clock with scoreboard bookkeeping for whatever handshakes occur at this edge.
  task automatic step();
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_output", out_p, 32'hxxxx_xxxx);
      else begin
        chk("stream", out_p, exp_q.pop_front());
        pops++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_p(in_k, in_x, in_zero));
      issued++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  ks[3];
    logic [14:0] xs[3];
    logic        zs[3];
    logic [31:0] es[3];
    errors = 0; checks = 0; pops = 0; issued = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 5'd0, 15'd0, 1'b0);
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_p", out_p, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Test 1: latency
    set_in(1'b1, 5'd3, 15'h6000, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 15'd0, 1'b0);
    #1;
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_p", out_p, 32'd14);
    tick();
    chk("t1_valid_clears", 32'(out_valid), 32'd0);
    chk("t1_p_held", out_p, 32'd14);

    // Test 2: corner values streamed back to back
    ks = '{5'd0, 5'd31, 5'd2};
    xs = '{15'h0000, 15'h7FFF, 15'h7FFF};
    zs = '{1'b0, 1'b0, 1'b1};
    es = '{32'd1, 32'hFFFF0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_in(1'b1, ks[i], xs[i], zs[i]);
      else set_in(1'b0, 5'd0, 15'd0, 1'b0);
      tick();
      if (i >= 1) begin
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_p", out_p, es[i-1]);
      end
    end

    // Test 3: 8 back-to-back powers of two
    for (int i = 0; i < 9; i++) begin
      if (i < 8) set_in(1'b1, 5'(i), 15'd0, 1'b0);
      else set_in(1'b0, 5'd0, 15'd0, 1'b0);
      #1;
      chk("t3_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (i >= 1) begin
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_p", out_p, 32'd1 << (i-1));
      end
    end
    tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // Test 4: backpressure
    exp_q.delete(); pops = 0;
    out_ready = 1'b0;
    set_in(1'b1, 5'd4, 15'h4000, 1'b0);
    #1; chk("t4_ready0", 32'(in_ready), 32'd1);
    step();
    set_in(1'b1, 5'd5, 15'h2000, 1'b0);
    #1; chk("t4_ready1", 32'(in_ready), 32'd1);
    step();
    set_in(1'b1, 5'd17, 15'h1234, 1'b0);
    #1;
    chk("t4_ready_falls", 32'(in_ready), 32'd0);
    chk("t4_stall_valid", 32'(out_valid), 32'd1);
    chk("t4_stall_p", out_p, 32'd24);
    held = out_p;
    step();
    step();
    chk("t4_p_stable", out_p, held);
    chk("t4_still_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    set_in(1'b1, 5'd20, 15'h7001, 1'b0);
    step();
    set_in(1'b0, 5'd0, 15'd0, 1'b0);
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_count", 32'(pops), 32'd4);

    // Test 5: reset with two ops in flight
    out_ready = 1'b0;
    set_in(1'b1, 5'd6, 15'd0, 1'b0);
    step();
    set_in(1'b1, 5'd7, 15'd0, 1'b0);
    step();
    set_in(1'b0, 5'd0, 15'd0, 1'b0);
    #1;
    chk("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_stale", 32'(out_valid), 32'd0);
    end

    // Test 6: randomized traffic against the model
    pops = 0; issued = 0; cyc = 0;
    while (issued < 10000 && cyc < 60000) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
             15'($urandom_range(0, 32767)), $urandom_range(0, 7) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      step();
      cyc++;
    end
    chk("t6_issued", 32'(issued), 32'd10000);
    set_in(1'b0, 5'd0, 15'd0, 1'b0);
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_count", 32'(pops), 32'd10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
